// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// InstQueue: instruction fetch queue. It is a small circular buffer between
// the fetch stage and decode. It holds (fetch PC, instruction) pairs in order.
// With BYPASS=1, an empty queue passes its input straight to the output in the
// same cycle.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   flush        pipeline flush (exception / ertn / mispredict)
//   in_valid     upstream entry valid
//   in_data      upstream entry payload
//   in_allowin   queue can accept an entry this cycle
//   out_valid    head entry valid for downstream
//   out_data     head entry payload
//   out_allowin  downstream accepts this cycle
//   count        current occupancy
// ---------------------------------------------------------------------------
module inst_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64,
  parameter int BYPASS = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_allowin,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_allowin,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_passThru;
  logic w_write;
  logic w_read;

  // The head is valid if the queue holds an entry. It is also valid when the
  // queue is empty and the bypass path forwards the incoming entry. Flush and
  // reset hide the head in their own cycle.
  always_comb begin
    w_empty    = (r_count == '0);
    w_full     = (r_count == FULL_CNT);
    out_valid  = (!w_empty || (BYPASS_EN && in_valid)) && !flush && !rst;
    out_data   = (BYPASS_EN && w_empty) ? in_data : r_mem[r_rdPtr];
    // A full queue still accepts an entry when the head leaves in the same
    // cycle. The new entry then lands in the slot that the head frees.
    in_allowin = !w_full || (out_allowin && out_valid);
    w_push     = in_valid && in_allowin && !flush;
    w_pop      = out_valid && out_allowin && !flush;
    // In bypass mode, an entry that is consumed in its arrival cycle passes
    // straight through. It never touches storage or the pointers.
    w_passThru = BYPASS_EN && w_empty && w_push && w_pop;
    w_write    = w_push && !w_passThru;
    w_read     = w_pop && !w_passThru;
  end

  // Storage is deliberately not reset. Stale contents are never observed,
  // because out_valid only reflects the occupancy.
  always_ff @(posedge clk) begin
    if (w_write && !rst) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  // Pointer and occupancy bookkeeping. Reset and flush both return the queue
  // to empty. DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_write) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_read) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_write, w_read})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue: directed bench for inst_queue. It has one instance with
// BYPASS=0 (dut0) and one with BYPASS=1 (dut1). Both use DEPTH=4 and
// DATA_W=64.
// ---------------------------------------------------------------------------
module tb_inst_queue;

  logic        clk = 1'b0;

  logic        rst0 = 1'b1, flush0 = 1'b0, inValid0 = 1'b0, outAllowin0 = 1'b0;
  logic [63:0] inData0 = '0;
  logic        inAllowin0, outValid0;
  logic [63:0] outData0;
  logic [2:0]  count0;

  logic        rst1 = 1'b1, flush1 = 1'b0, inValid1 = 1'b0, outAllowin1 = 1'b0;
  logic [63:0] inData1 = '0;
  logic        inAllowin1, outValid1;
  logic [63:0] outData1;
  logic [2:0]  count1;

  int numCompared   = 0;
  int numMismatched = 0;

  // Scoreboard state for the random-stall streaming test.
  logic [63:0] expQ[$];
  int          sent, recvd, mCount;
  logic        stall, expAllowin, pushNow, popNow;
  logic [63:0] rndData;
  logic [63:0] drainExp [4];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(4), .DATA_W(64), .BYPASS(0)) dut0 (
    .clk(clk), .rst(rst0), .flush(flush0), .in_valid(inValid0), .in_data(inData0),
    .in_allowin(inAllowin0), .out_valid(outValid0), .out_data(outData0),
    .out_allowin(outAllowin0), .count(count0)
  );

  inst_queue #(.DEPTH(4), .DATA_W(64), .BYPASS(1)) dut1 (
    .clk(clk), .rst(rst1), .flush(flush1), .in_valid(inValid1), .in_data(inData1),
    .in_allowin(inAllowin1), .out_valid(outValid1), .out_data(outData1),
    .out_allowin(outAllowin1), .count(count1)
  );

  // Drives one cycle of inputs on the falling edge. It then lets the
  // combinational outputs settle, so checks see the state left by the last
  // rising edge.
  task automatic applyStimulus(input bit sel, input logic r, input logic f,
                               input logic iv, input logic [63:0] id, input logic oa);
    @(negedge clk);
    if (!sel) begin
      rst0 = r; flush0 = f; inValid0 = iv; inData0 = id; outAllowin0 = oa;
    end else begin
      rst1 = r; flush1 = f; inValid1 = iv; inData1 = id; outAllowin1 = oa;
    end
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    drainExp[0] = 64'h1C00_0000_0000_000B;
    drainExp[1] = 64'h1C00_0000_0000_000C;
    drainExp[2] = 64'h1C00_0000_0000_000D;
    drainExp[3] = 64'h1C00_0000_0000_000E;

    // Reset state of the non-bypass queue.
    applyStimulus(0, 1, 0, 0, '0, 0);
    applyStimulus(0, 1, 0, 1, 64'hDEAD, 1);
    checkOutput("rstCount", count0, 0);
    checkOutput("rstValid", outValid0, 0);
    checkOutput("rstAllowin", inAllowin0, 1);

    // Fill A..D with the downstream stalled.
    applyStimulus(0, 0, 0, 1, 64'h1C00_0000_0000_000A, 0);
    checkOutput("fillA_count", count0, 0);
    checkOutput("fillA_valid", outValid0, 0);
    applyStimulus(0, 0, 0, 1, 64'h1C00_0000_0000_000B, 0);
    checkOutput("fillB_count", count0, 1);
    checkOutput("fillB_valid", outValid0, 1);
    checkOutput("fillB_head", outData0, 64'h1C00_0000_0000_000A);
    applyStimulus(0, 0, 0, 1, 64'h1C00_0000_0000_000C, 0);
    checkOutput("fillC_count", count0, 2);
    applyStimulus(0, 0, 0, 1, 64'h1C00_0000_0000_000D, 0);
    checkOutput("fillD_count", count0, 3);
    checkOutput("fillD_allowin", inAllowin0, 1);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("full_count", count0, 4);
    checkOutput("full_allowin", inAllowin0, 0);
    checkOutput("full_head", outData0, 64'h1C00_0000_0000_000A);

    // Push E and pop A together while the queue is full.
    applyStimulus(0, 0, 0, 1, 64'h1C00_0000_0000_000E, 1);
    checkOutput("fullPP_allowin", inAllowin0, 1);
    checkOutput("fullPP_head", outData0, 64'h1C00_0000_0000_000A);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("fullPP_count", count0, 4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, '0, 1);
      checkOutput("drainValid", outValid0, 1);
      checkOutput("drainData", outData0, drainExp[i]);
    end
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("drained_count", count0, 0);
    checkOutput("drained_valid", outValid0, 0);

    // Stream ten entries with random downstream stalls against a scoreboard.
    sent = 0; recvd = 0; mCount = 0;
    for (int cyc = 0; cyc < 300 && recvd < 10; cyc++) begin
      stall = ($urandom_range(0, 2) == 0);
      rndData = 64'hA5A5_0000_0000_0000 + 64'(sent);
      applyStimulus(0, 0, 0, (sent < 10), rndData, !stall);
      expAllowin = (mCount != 4) || (!stall && mCount != 0);
      checkOutput("rndValid", outValid0, (mCount != 0));
      checkOutput("rndCount", count0, 64'(mCount));
      checkOutput("rndAllowin", inAllowin0, expAllowin);
      pushNow = (sent < 10) && expAllowin;
      popNow  = !stall && (mCount != 0);
      if (popNow) begin
        checkOutput("rndData", outData0, expQ[0]);
        void'(expQ.pop_front());
        recvd++;
      end
      if (pushNow) begin
        expQ.push_back(rndData);
        sent++;
      end
      mCount = mCount + (pushNow ? 1 : 0) - (popNow ? 1 : 0);
    end
    checkOutput("rndReceived", 64'(recvd), 10);

    // Flush with three entries held and a live push/pop request.
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_0F01, 0);
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_0F02, 0);
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_0F03, 0);
    applyStimulus(0, 0, 1, 1, 64'h0000_0000_0000_0BAD, 1);
    checkOutput("flush_valid", outValid0, 0);
    checkOutput("flush_countBefore", count0, 3);
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_1001, 0);
    checkOutput("postFlush_count", count0, 0);
    checkOutput("postFlush_valid", outValid0, 0);
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_1002, 0);
    checkOutput("postFlush_head", outData0, 64'h0000_0000_0000_1001);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("preRst_count", count0, 2);

    // Reset in the middle of operation, then the first push becomes the head.
    applyStimulus(0, 1, 0, 0, '0, 0);
    applyStimulus(0, 1, 0, 0, '0, 1);
    checkOutput("midRst_count", count0, 0);
    checkOutput("midRst_valid", outValid0, 0);
    checkOutput("midRst_allowin", inAllowin0, 1);
    applyStimulus(0, 0, 0, 1, 64'h0000_0000_0000_00FF, 0);
    applyStimulus(0, 0, 0, 0, '0, 0);
    checkOutput("afterRst_valid", outValid0, 1);
    checkOutput("afterRst_head", outData0, 64'h0000_0000_0000_00FF);
    checkOutput("afterRst_count", count0, 1);

    // Bypass queue: the entry passes through while the queue is empty.
    applyStimulus(1, 1, 0, 0, '0, 0);
    applyStimulus(1, 1, 0, 1, 64'h1234, 1);
    checkOutput("bypRst_valid", outValid1, 0);
    checkOutput("bypRst_count", count1, 0);
    applyStimulus(1, 0, 0, 1, 64'h1C00_0000_0280_0413, 1);
    checkOutput("byp_valid", outValid1, 1);
    checkOutput("byp_data", outData1, 64'h1C00_0000_0280_0413);
    applyStimulus(1, 0, 0, 0, '0, 0);
    checkOutput("byp_countStays", count1, 0);
    checkOutput("byp_idleValid", outValid1, 0);
    applyStimulus(1, 0, 0, 1, 64'h1C00_0000_0280_0413, 0);
    checkOutput("bypStall_valid", outValid1, 1);
    applyStimulus(1, 0, 0, 0, '0, 0);
    checkOutput("bypStall_count", count1, 1);
    checkOutput("bypStall_head", outData1, 64'h1C00_0000_0280_0413);
    applyStimulus(1, 0, 0, 0, '0, 1);
    applyStimulus(1, 0, 0, 0, '0, 0);
    checkOutput("bypDrain_count", count1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, default 4; number of entries, power of two, range 2..32.
REQ-002 Parameter DATA_W, default 64; entry width (fetch PC + instruction word).
REQ-003 Parameter BYPASS, default 0; 1 = an empty queue forwards its input to the output in the same cycle.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-high.
REQ-006 Port flush  input  1  pipeline flush (exception / ertn / mispredict), synchronous.
REQ-007 Port in_valid  input  1  upstream entry valid.
REQ-008 Port in_data  input  DATA_W  upstream entry payload.
REQ-009 Port in_allowin  output  1  queue can accept an entry this cycle.
REQ-010 Port out_valid  output  1  head entry valid for downstream.
REQ-011 Port out_data  output  DATA_W  head entry payload.
REQ-012 Port out_allowin  input  1  downstream accepts this cycle.
REQ-013 Port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Push SHALL occur when in_valid & in_allowin & !flush; pop SHALL occur when out_valid & out_allowin & !flush.
REQ-015 Storage SHALL be a circular buffer with wr_ptr and rd_ptr of width $clog2(DEPTH); both wrap from DEPTH-1 to 0.
REQ-016 count SHALL update as: push only +1, pop only -1, push and pop 0, neither 0.
REQ-017 in_allowin SHALL be (count != DEPTH) | (out_allowin & out_valid); it is combinational from out_allowin.
REQ-018 When full, a simultaneous push and pop SHALL keep count == DEPTH and write the new entry into the freed slot.
REQ-019 When BYPASS=0, out_valid SHALL be (count != 0) and out_data SHALL be the entry at rd_ptr.
REQ-020 When BYPASS=0, latency from push to out_valid SHALL be 1 cycle.
REQ-021 When BYPASS=1 and count == 0, out_valid SHALL equal in_valid and out_data SHALL equal in_data in the same cycle.
REQ-022 When BYPASS=1, an entry popped from an empty queue in its arrival cycle SHALL NOT be written: pointers and count stay unchanged.
REQ-023 When BYPASS=1 and count == 0 with in_valid & !out_allowin, the entry SHALL be stored (count becomes 1).
REQ-024 When flush is high, out_valid SHALL be 0 in that cycle, and no push or pop SHALL occur.
REQ-025 When flush is high, wr_ptr, rd_ptr and count SHALL be 0 on the next edge.
REQ-026 flush SHALL take priority over push and pop; rst SHALL take priority over flush.
REQ-027 An empty queue SHALL never assert out_valid, except through the BYPASS path of REQ-021.
REQ-028 Storage contents SHALL NOT be reset; out_data is don't-care whenever out_valid == 0.

Reset
REQ-029 While rst is high, on each edge wr_ptr, rd_ptr and count SHALL be 0.
REQ-030 While rst is high, out_valid SHALL be 0 and in_allowin SHALL be 1, from the first edge with rst high onward.
REQ-031 A reset asserted mid-operation SHALL discard all entries; the first push after rst deasserts SHALL appear as the head.

Verification
REQ-032 DEPTH=4, BYPASS=0, out_allowin=0: push A,B,C,D -> count 1,2,3,4; in_allowin=0 after D; out_data=A.
REQ-033 Full queue, in_valid=1 with E, out_allowin=1 for one cycle -> A popped, E stored, count stays 4; drain order B,C,D,E.
REQ-034 Push/pop 10 entries with random out_allowin stalls -> output order identical to input order; pointers wrap at 3->0 with no loss or duplicate.
REQ-035 count=3, assert flush with in_valid=1 and out_allowin=1 -> out_valid=0 that cycle, count=0 next cycle, flushed input not stored.
REQ-036 BYPASS=1, empty, in_valid=1 with data 0x1C000000_02800413, out_allowin=1 -> out_valid=1 and same data that cycle, count stays 0; repeat with out_allowin=0 -> count=1.
REQ-037 rst asserted with count=2 -> count=0 and out_valid=0 next cycle; next push F appears as head one cycle later.
